// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM states shared by the ALU and the control unit
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic op_is_divrem(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring unsigned divider
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] acc_nxt_o,
  output logic [WIDTH-1:0] quo_nxt_o
);
  localparam int SHW = $clog2(WIDTH);

  // acc: product or partial remainder; shf: multiplier or dividend/quotient;
  // opb: multiplicand or divisor
  logic             div_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, shf_q, opb_q;
  logic [WIDTH-1:0] acc_nxt, shf_nxt, opb_nxt;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  assign rem_shift = {acc_q, shf_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opb_q};

  always_comb begin
    acc_nxt = acc_q;
    shf_nxt = shf_q;
    opb_nxt = opb_q;
    if (div_q) begin
      if (rem_ge) begin
        acc_nxt = WIDTH'(rem_shift - {1'b0, opb_q});
        shf_nxt = {shf_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_shift[WIDTH-1:0];
        shf_nxt = {shf_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shf_q[0]) acc_nxt = acc_q + opb_q;
      shf_nxt = shf_q >> 1;
      opb_nxt = opb_q << 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      shf_q <= '0;
      opb_q <= '0;
    end else if (start_i) begin
      div_q <= is_div_i;
      cnt_q <= SHW'(WIDTH - 1);
      acc_q <= '0;
      shf_q <= is_div_i ? a_i : b_i;
      opb_q <= is_div_i ? b_i : a_i;
    end else if (step_i) begin
      acc_q <= acc_nxt;
      shf_q <= shf_nxt;
      opb_q <= opb_nxt;
      if (cnt_q != '0) cnt_q <= cnt_q - SHW'(1);
    end
  end

  assign last_o    = (cnt_q == '0);
  assign acc_nxt_o = acc_nxt;
  assign quo_nxt_o = shf_nxt;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU with valid/ready handshake and iterative mul/div
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             err_o
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] data_q, single_res, iter_acc, iter_quo, muldiv_res;
  logic             zero_q, err_q, single_err;
  logic             accept, is_long, start, step, last;
  logic [SHW-1:0]   sh;

  assign sh      = data2_i[SHW-1:0];
  assign accept  = (state_q == ST_IDLE) && valid_i && !kill_i;
  // Divide by zero resolves in one cycle, so only a nonzero divisor goes iterative
  assign is_long = (ALUCtrl_i == OP_MUL) || (op_is_divrem(ALUCtrl_i) && (data2_i != '0));
  assign start   = accept && is_long;
  assign step    = (state_q == ST_BUSY);

  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (ALUCtrl_i)
      OP_ADD:  single_res = data1_i + data2_i;
      OP_SUB:  single_res = data1_i - data2_i;
      OP_MUL:  single_res = '0;
      OP_AND:  single_res = data1_i & data2_i;
      OP_XOR:  single_res = data1_i ^ data2_i;
      OP_SLL:  single_res = data1_i << sh;
      OP_SRA:  single_res = $signed(data1_i) >>> sh;
      OP_OR:   single_res = data1_i | data2_i;
      OP_SRL:  single_res = data1_i >> sh;
      OP_DIVU: begin single_res = '1;      single_err = 1'b1; end
      OP_REMU: begin single_res = data1_i; single_err = 1'b1; end
      default: single_err = 1'b1;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (start),
    .step_i    (step),
    .is_div_i  (op_is_divrem(ALUCtrl_i)),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .last_o    (last),
    .acc_nxt_o (iter_acc),
    .quo_nxt_o (iter_quo)
  );

  assign muldiv_res = (op_q == OP_DIVU) ? iter_quo : iter_acc;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_long ? ST_BUSY : ST_DONE;
      ST_BUSY: if (kill_i) state_d = ST_IDLE;
               else if (last) state_d = ST_DONE;
      ST_DONE: if (kill_i || ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == ST_IDLE);
    valid_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      data_q <= '0;
      zero_q <= 1'b1;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q <= ALUCtrl_i;
      if (!is_long) begin
        data_q <= single_res;
        zero_q <= (single_res == '0);
        err_q  <= single_err;
      end
    end else if (step && last && !kill_i) begin
      data_q <= muldiv_res;
      zero_q <= (muldiv_res == '0);
      err_q  <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign Zero_o = zero_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed and randomized checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_o, kill_i, valid_o, ready_i, Zero_o, err_o;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i, data_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .kill_i    (kill_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .err_o     (err_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // result, error flag and edges from acceptance until valid_o
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic err, output int lat);
    int unsigned sh;
    sh  = b % 32;
    err = 1'b0;
    lat = 1;
    case (op)
      4'd1:  res = a + b;
      4'd2:  res = a - b;
      4'd3:  begin res = a * b; lat = 33; end
      4'd4:  res = a & b;
      4'd5:  res = a ^ b;
      4'd6:  res = a << sh;
      4'd7:  res = $signed(a) >>> sh;
      4'd8:  res = a | b;
      4'd9:  res = a >> sh;
      4'd10: if (b == 0) begin res = 32'hFFFF_FFFF; err = 1'b1; end
             else begin res = a / b; lat = 33; end
      4'd11: if (b == 0) begin res = a; err = 1'b1; end
             else begin res = a % b; lat = 33; end
      default: begin res = 32'h0; err = 1'b1; end
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_data"},  data_o,  0);
    chk({tag, "_zero"},  Zero_o,  1);
    chk({tag, "_err"},   err_o,   0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0; ALUCtrl_i = 4'($urandom); data1_i = $urandom; data2_i = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ee;
    int          el, lat;
    logic        rdy_seen;
    ref_model(op, a, b, er, ee, el);
    @(negedge clk);
    chk({tag, "_ready_idle"}, ready_o, 1);
    issue(op, a, b);
    lat = 1;
    rdy_seen = 1'b0;
    while (!valid_o && lat < 80) begin
      if (ready_o) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_ready_low"}, rdy_seen, 0);
    chk({tag, "_data"}, data_o, er);
    chk({tag, "_zero"}, Zero_o, (er == 0));
    chk({tag, "_err"},  err_o,  ee);
    repeat (hold) begin @(posedge clk); #1; end
    chk({tag, "_hold_valid"}, valid_o, 1);
    chk({tag, "_hold_data"},  data_o,  er);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, "_ack_valid"}, valid_o, 0);
    chk({tag, "_ack_ready"}, ready_o, 1);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
    ALUCtrl_i = 4'd0; data1_i = 32'd0; data2_i = 32'd0;
    repeat (2) @(posedge clk); #1;
    check_reset_values("rst");
    @(negedge clk); rst_n = 1'b1;

    // reset asserted in the middle of a multiply
    issue(4'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    do_op("after_rst_add", 4'd1, 32'd10, 32'd20, 0);

    do_op("add_wrap", 4'd1, 32'h7FFF_FFFF, 32'd1, 0);
    do_op("sub_zero", 4'd2, 32'd5, 32'd5, 0);
    do_op("mul_neg1x3", 4'd3, 32'hFFFF_FFFF, 32'd3, 0);
    do_op("divu", 4'd10, 32'd100, 32'd7, 0);
    do_op("remu", 4'd11, 32'd100, 32'd7, 0);
    do_op("divu_by0", 4'd10, 32'd1234, 32'd0, 0);
    do_op("remu_by0", 4'd11, 32'd9, 32'd0, 0);
    do_op("sra", 4'd7, 32'h8000_0000, 32'h24, 0);
    do_op("srl", 4'd9, 32'h8000_0000, 32'h24, 0);
    do_op("illegal", 4'd15, 32'hDEAD_BEEF, 32'h1, 0);
    do_op("hold5", 4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234, 5);

    // abort a multiply ten cycles after acceptance, then accept immediately
    issue(4'd3, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(posedge clk);
    @(negedge clk); kill_i = 1'b1;
    @(posedge clk); #1; kill_i = 1'b0;
    chk("kill_busy_valid", valid_o, 0);
    chk("kill_busy_ready", ready_o, 1);
    do_op("after_kill_add", 4'd1, 32'd3, 32'd4, 0);

    // abort a finished result before it is consumed
    issue(4'd8, 32'hF0, 32'h0F);
    @(negedge clk);
    chk("done_before_kill", valid_o, 1);
    kill_i = 1'b1;
    @(posedge clk); #1; kill_i = 1'b0;
    chk("kill_done_valid", valid_o, 0);

    // kill in IDLE blocks acceptance
    @(negedge clk);
    valid_i = 1'b1; kill_i = 1'b1; ALUCtrl_i = 4'd1; data1_i = 32'd1; data2_i = 32'd1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle_ready", ready_o, 1);
    chk("kill_idle_valid", valid_o, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
